// File: rtl/ex_stage_pipe.sv
// RV32I execute stage: forwarding operand select, ALU, branch target, and the
// EX/MEM pipeline register with stall (hold) and flush (bubble).
module ex_stage_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_ID_EX,
    input  logic [XLEN-1:0] rs1Data_ID_EX,
    input  logic [XLEN-1:0] rs2Data_ID_EX,
    input  logic [XLEN-1:0] imm_ID_EX,
    input  logic [4:0]      writeReg_ID_EX,
    input  logic            ALUSrc_ID_EX,
    input  logic [3:0]      ALUCtl_ID_EX,
    input  logic            branch_ID_EX,
    input  logic            MemRead_ID_EX,
    input  logic            MemWrite_ID_EX,
    input  logic            MemtoReg_ID_EX,
    input  logic            RegWrite_ID_EX,
    input  logic [1:0]      Fwd_A,
    input  logic [1:0]      Fwd_B,
    input  logic [XLEN-1:0] wbData_MEM_WB,
    output logic [XLEN-1:0] aluResult_EX_MEM,
    output logic [XLEN-1:0] storeData_EX_MEM,
    output logic [XLEN-1:0] branchTarget_EX_MEM,
    output logic            zero_EX_MEM,
    output logic [4:0]      writeReg_EX_MEM,
    output logic            branch_EX_MEM,
    output logic            MemRead_EX_MEM,
    output logic            MemWrite_EX_MEM,
    output logic            MemtoReg_EX_MEM,
    output logic            RegWrite_EX_MEM
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};

    // Select 11 is unused by the forwarding unit and falls back to the register value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] ex_mem_val,
        input logic [XLEN-1:0] mem_wb_val
    );
        logic [XLEN-1:0] res;
        case (sel)
            2'b10:   res = ex_mem_val;
            2'b01:   res = mem_wb_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    logic [XLEN-1:0] op_a_s, fwd_b_s, op_b_s, alu_res_s, br_tgt_s;
    logic [4:0]      shamt_s;

    logic [XLEN-1:0] alu_q, alu_d, store_q, store_d, br_q, br_d;
    logic            zero_q, zero_d;
    logic [4:0]      wr_q, wr_d;
    logic            branch_q, branch_d, mrd_q, mrd_d, mwr_q, mwr_d;
    logic            m2r_q, m2r_d, rw_q, rw_d;

    assign op_a_s   = fwd_sel(Fwd_A, rs1Data_ID_EX, alu_q, wbData_MEM_WB);
    assign fwd_b_s  = fwd_sel(Fwd_B, rs2Data_ID_EX, alu_q, wbData_MEM_WB);
    assign op_b_s   = ALUSrc_ID_EX ? imm_ID_EX : fwd_b_s;
    assign shamt_s  = op_b_s[4:0];
    assign br_tgt_s = pc_ID_EX + imm_ID_EX;

    // ALU operation decode.
    always_comb begin
        alu_res_s = ZERO_W;
        case (ALUCtl_ID_EX)
            ALU_AND:  alu_res_s = op_a_s & op_b_s;
            ALU_OR:   alu_res_s = op_a_s | op_b_s;
            ALU_ADD:  alu_res_s = op_a_s + op_b_s;
            ALU_XOR:  alu_res_s = op_a_s ^ op_b_s;
            ALU_SLL:  alu_res_s = op_a_s << shamt_s;
            ALU_SRL:  alu_res_s = op_a_s >> shamt_s;
            ALU_SUB:  alu_res_s = op_a_s - op_b_s;
            ALU_SLT:  alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? ONE_W : ZERO_W;
            ALU_SRA:  alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
            ALU_SLTU: alu_res_s = (op_a_s < op_b_s) ? ONE_W : ZERO_W;
            default:  alu_res_s = ZERO_W;
        endcase
    end

    // EX/MEM next state: flush beats stall, stall holds, otherwise capture.
    always_comb begin
        alu_d    = alu_q;
        store_d  = store_q;
        br_d     = br_q;
        zero_d   = zero_q;
        wr_d     = wr_q;
        branch_d = branch_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        m2r_d    = m2r_q;
        rw_d     = rw_q;
        if (flush) begin
            alu_d    = ZERO_W;
            store_d  = ZERO_W;
            br_d     = ZERO_W;
            zero_d   = 1'b0;
            wr_d     = 5'd0;
            branch_d = 1'b0;
            mrd_d    = 1'b0;
            mwr_d    = 1'b0;
            m2r_d    = 1'b0;
            rw_d     = 1'b0;
        end else if (stall) begin
            alu_d    = alu_q;
            store_d  = store_q;
        end else begin
            alu_d    = alu_res_s;
            store_d  = fwd_b_s;
            br_d     = br_tgt_s;
            zero_d   = (alu_res_s == ZERO_W);
            wr_d     = writeReg_ID_EX;
            branch_d = branch_ID_EX;
            mrd_d    = MemRead_ID_EX;
            mwr_d    = MemWrite_ID_EX;
            m2r_d    = MemtoReg_ID_EX;
            rw_d     = RegWrite_ID_EX;
        end
    end

    // EX/MEM register bank with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q    <= ZERO_W;
            store_q  <= ZERO_W;
            br_q     <= ZERO_W;
            zero_q   <= 1'b0;
            wr_q     <= 5'd0;
            branch_q <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            m2r_q    <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            alu_q    <= alu_d;
            store_q  <= store_d;
            br_q     <= br_d;
            zero_q   <= zero_d;
            wr_q     <= wr_d;
            branch_q <= branch_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            m2r_q    <= m2r_d;
            rw_q     <= rw_d;
        end
    end

    assign aluResult_EX_MEM    = alu_q;
    assign storeData_EX_MEM    = store_q;
    assign branchTarget_EX_MEM = br_q;
    assign zero_EX_MEM         = zero_q;
    assign writeReg_EX_MEM     = wr_q;
    assign branch_EX_MEM       = branch_q;
    assign MemRead_EX_MEM      = mrd_q;
    assign MemWrite_EX_MEM     = mwr_q;
    assign MemtoReg_EX_MEM     = m2r_q;
    assign RegWrite_EX_MEM     = rw_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a behavioural model checked on every
// falling edge, plus hand-computed literal checks on the key vectors.
module tb_ex_stage_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic [31:0] pc = 32'd0, rs1 = 32'd0, rs2 = 32'd0, imm = 32'd0, wb = 32'd0;
    logic [4:0]  wreg = 5'd0;
    logic        alusrc = 1'b0;
    logic [3:0]  ctl = 4'd0;
    logic        br_i = 1'b0, mr_i = 1'b0, mw_i = 1'b0, m2r_i = 1'b0, rw_i = 1'b0;
    logic [1:0]  fa = 2'd0, fb = 2'd0;

    logic [31:0] alu_o, st_o, bt_o;
    logic        z_o, br_o, mr_o, mw_o, m2r_o, rw_o;
    logic [4:0]  wr_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    ex_stage_pipe #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .pc_ID_EX(pc), .rs1Data_ID_EX(rs1), .rs2Data_ID_EX(rs2), .imm_ID_EX(imm),
        .writeReg_ID_EX(wreg), .ALUSrc_ID_EX(alusrc), .ALUCtl_ID_EX(ctl),
        .branch_ID_EX(br_i), .MemRead_ID_EX(mr_i), .MemWrite_ID_EX(mw_i),
        .MemtoReg_ID_EX(m2r_i), .RegWrite_ID_EX(rw_i),
        .Fwd_A(fa), .Fwd_B(fb), .wbData_MEM_WB(wb),
        .aluResult_EX_MEM(alu_o), .storeData_EX_MEM(st_o),
        .branchTarget_EX_MEM(bt_o), .zero_EX_MEM(z_o), .writeReg_EX_MEM(wr_o),
        .branch_EX_MEM(br_o), .MemRead_EX_MEM(mr_o), .MemWrite_EX_MEM(mw_o),
        .MemtoReg_EX_MEM(m2r_o), .RegWrite_EX_MEM(rw_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the EX/MEM stage must be holding.
    logic [31:0] m_alu = 32'd0, m_st = 32'd0, m_bt = 32'd0;
    logic        m_z = 1'b0;
    logic [4:0]  m_wr = 5'd0;
    logic [4:0]  m_ctl = 5'd0;

    function automatic logic [31:0] m_pick(input logic [1:0] f, input logic [31:0] regv,
                                           input logic [31:0] prev, input logic [31:0] wbv);
        if (f == 2'b10) return prev;
        if (f == 2'b01) return wbv;
        return regv;
    endfunction

    function automatic logic [31:0] m_op(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            4'd6: return a - b;
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            4'd8: return sa >>> b[4:0];
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model update mirrors the externally visible pipeline-register behaviour.
    always @(posedge clk or negedge reset) begin
        logic [31:0] a, fbv, r;
        if (!reset) begin
            m_alu <= 32'd0; m_st <= 32'd0; m_bt <= 32'd0;
            m_z <= 1'b0; m_wr <= 5'd0; m_ctl <= 5'd0;
        end else if (flush) begin
            m_alu <= 32'd0; m_st <= 32'd0; m_bt <= 32'd0;
            m_z <= 1'b0; m_wr <= 5'd0; m_ctl <= 5'd0;
        end else if (!stall) begin
            a   = m_pick(fa, rs1, m_alu, wb);
            fbv = m_pick(fb, rs2, m_alu, wb);
            r   = m_op(ctl, a, alusrc ? imm : fbv);
            m_alu <= r;
            m_st  <= fbv;
            m_bt  <= pc + imm;
            m_z   <= (r == 32'd0);
            m_wr  <= wreg;
            m_ctl <= {br_i, mr_i, mw_i, m2r_i, rw_i};
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_alu", alu_o, m_alu);
            chk("m_store", st_o, m_st);
            chk("m_btgt", bt_o, m_bt);
            chk("m_zero", {31'd0, z_o}, {31'd0, m_z});
            chk("m_wreg", {27'd0, wr_o}, {27'd0, m_wr});
            chk("m_ctl", {27'd0, br_o, mr_o, mw_o, m2r_o, rw_o}, {27'd0, m_ctl});
        end
    end

    task automatic vec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] f_a, input logic [1:0] f_b);
        ctl = c; rs1 = a; rs2 = b; fa = f_a; fb = f_b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_alu", alu_o, 32'd0);
        chk("reset_ctl", {27'd0, br_o, mr_o, mw_o, m2r_o, rw_o}, 32'd0);
        chk_en = 1'b1;
        tick();
        reset = 1'b1;

        // 1: ADD 5+7
        vec(4'd2, 32'd5, 32'd7, 2'b00, 2'b00); rw_i = 1'b1; wreg = 5'd3; pc = 32'h100; imm = 32'd4;
        tick();
        chk("t1_add", alu_o, 32'd12);
        chk("t1_zero", {31'd0, z_o}, 32'd0);
        chk("t1_rw", {31'd0, rw_o}, 32'd1);
        chk("t1_btgt", bt_o, 32'h104);

        // 2: SUB with Fwd_A=10, then Fwd_B=01
        vec(4'd6, 32'd100, 32'd3, 2'b10, 2'b00);
        tick();
        chk("t2_fwdA", alu_o, 32'd9);
        vec(4'd6, 32'h20, 32'd99, 2'b00, 2'b01); wb = 32'h10;
        tick();
        chk("t2_fwdB", alu_o, 32'h10);
        chk("t2_store", st_o, 32'h10);

        // 3: SW with immediate, store data forwarded from EX/MEM
        vec(4'd2, 32'h100, 32'h55, 2'b00, 2'b10); alusrc = 1'b1; imm = 32'd8;
        mw_i = 1'b1; rw_i = 1'b0;
        tick();
        chk("t3_addr", alu_o, 32'h108);
        chk("t3_store", st_o, 32'h10);
        chk("t3_mw", {31'd0, mw_o}, 32'd1);
        alusrc = 1'b0; mw_i = 1'b0; rw_i = 1'b1; imm = 32'd0;

        // 4: corner ALU ops
        vec(4'd7, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00); tick(); chk("t4_slt", alu_o, 32'd1);
        vec(4'd9, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00); tick(); chk("t4_sltu", alu_o, 32'd0);
        vec(4'd8, 32'h8000_0000, 32'd4, 2'b00, 2'b00); tick(); chk("t4_sra", alu_o, 32'hF800_0000);
        vec(4'd5, 32'h8000_0000, 32'd4, 2'b00, 2'b00); tick(); chk("t4_srl", alu_o, 32'h0800_0000);
        vec(4'd4, 32'h0000_0003, 32'd31, 2'b00, 2'b00); tick(); chk("t4_sll", alu_o, 32'h8000_0000);
        vec(4'd2, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00); tick();
        chk("t4_wrap", alu_o, 32'd0);
        chk("t4_zero", {31'd0, z_o}, 32'd1);
        vec(4'd2, 32'd7, 32'd2, 2'b11, 2'b11); tick(); chk("t4_fwd11", alu_o, 32'd9);
        vec(4'd3, 32'hF0F0_0000, 32'h0FF0_0000, 2'b00, 2'b00); tick(); chk("t4_xor", alu_o, 32'hFF00_0000);
        vec(4'd15, 32'd7, 32'd2, 2'b00, 2'b00); tick(); chk("t4_bad_op", alu_o, 32'd0);

        // 5: stall holds, stall+flush bubbles
        vec(4'd2, 32'd1, 32'd2, 2'b00, 2'b00); wreg = 5'd9; tick();
        chk("t5_pre", alu_o, 32'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec(4'd1, 32'h1000 + i, 32'h77, 2'b00, 2'b00); wreg = 5'(i); rw_i = i[0];
            tick();
            chk("t5_hold_alu", alu_o, 32'd3);
            chk("t5_hold_wr", {27'd0, wr_o}, 32'd9);
            chk("t5_hold_rw", {31'd0, rw_o}, 32'd1);
        end
        flush = 1'b1; tick();
        chk("t5_flush_ctl", {27'd0, br_o, mr_o, mw_o, m2r_o, rw_o}, 32'd0);
        chk("t5_flush_alu", alu_o, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // 6: asynchronous reset between edges
        vec(4'd2, 32'd4, 32'd4, 2'b00, 2'b00); rw_i = 1'b1; tick();
        chk("t6_pre", alu_o, 32'd8);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_alu", alu_o, 32'd0);
        chk("t6_async_rw", {31'd0, rw_o}, 32'd0);
        stall = 1'b1; flush = 1'b1; tick();
        chk("t6_held", alu_o, 32'd0);
        stall = 1'b0; flush = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        vec(4'd2, 32'd10, 32'd20, 2'b00, 2'b00);
        tick();
        chk("t6_first_cap", alu_o, 32'd30);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
